rc4_key_sequencer: RTL
======================

RC4_KEY_SEQUENCER -- requirements
Module: rc4_key_sequencer

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, meaning the byte width of each key byte.
REQ-002 SHALL have parameter KEY_LENGTH, default 3, meaning the number of key bytes.
REQ-003 SHALL have parameter KEY_MAX, default 24'h3FFFFF, meaning the last key value searched.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the phase watchdog limit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin a search from key_start (accepted in IDLE/terminal states only).
REQ-008 SHALL have port halt, input, 1 bit: abort any search and return to IDLE.
REQ-009 SHALL have port key_start, input, KEY_LENGTH x RAM_WIDTH: first key; index KEY_LENGTH-1 is the most significant byte.
REQ-010 SHALL have port finished, input, 3 bits: done flags; bit0 initializer, bit1 shuffler, bit2 decryptor.
REQ-011 SHALL have port msg_valid, input, 1 bit: decryptor verdict, valid while finished[2]=1.
REQ-012 SHALL have port mode, output, 3 bits: registered phase select to the RAM controller.
REQ-013 SHALL have port key, output, KEY_LENGTH x RAM_WIDTH: registered current candidate key.
REQ-014 SHALL have ports busy, found, exhausted and timeout_err, outputs, 1 bit each: registered status flags.

Function
REQ-015 SHALL implement the states IDLE, INIT, SHUFFLE, DECRYPT, GAP, FOUND, EXHAUSTED and ERR.
REQ-016 SHALL drive mode 3'b001 in INIT, 3'b010 in SHUFFLE, 3'b100 in DECRYPT and 3'b000 in every other state.
REQ-017 SHALL, on start in IDLE/FOUND/EXHAUSTED/ERR, load key<=key_start, clear found/exhausted/timeout_err, set busy, and enter INIT on the next edge.
REQ-018 SHALL, on each phase entry, clear an arm flag and the watchdog counter.
REQ-019 SHALL set arm when its phase's finished bit is sampled 0; the phase completes only when arm=1 and that bit is sampled 1, so stale finished from a prior pass is ignored.
REQ-020 SHALL, on completion of INIT or SHUFFLE, enter GAP for exactly 2 cycles, then the next phase (INIT->SHUFFLE->DECRYPT).
REQ-021 SHALL, on DECRYPT completion, sample msg_valid in the same cycle.
REQ-022 SHALL, if msg_valid=1, enter FOUND, set found=1, clear busy, and hold key.
REQ-023 SHALL, if msg_valid=0 and key==KEY_MAX, enter EXHAUSTED, set exhausted=1, clear busy, and hold key.
REQ-024 SHALL, if msg_valid=0 and key<KEY_MAX, set key<=key+1 (flat binary, carries across bytes), then GAP(2) and INIT.
REQ-025 SHALL, when the watchdog reaches TIMEOUT_CYCLES-1 in INIT/SHUFFLE/DECRYPT without completion, enter ERR, set timeout_err=1, and clear busy.
REQ-026 SHALL, on halt from any state, enter IDLE next edge with mode=000 and busy=0; status flags clear, key holds.
REQ-027 SHALL give halt priority when start and halt are asserted together.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL let completion win over timeout when both occur in the same cycle.
REQ-030 SHALL keep found, exhausted and timeout_err sticky until the next accepted start, halt or reset.

Reset
REQ-031 SHALL, on reset=0 asynchronously, enter IDLE with mode=000, key=0, busy=0, found=0, exhausted=0, timeout_err=0, arm=0 and watchdog=0.
REQ-032 SHALL abandon any in-progress phase on reset mid-search; no key advance.
REQ-033 SHALL have its first state change occur on the first clk edge after reset deasserts.

Structure
REQ-034 SHALL place the mode codes (enum mode_t: IDLE 000, INIT 001, SHUFFLE 010, DECRYPT 100), the state enum, and RAM_WIDTH/KEY_LENGTH defaults in the shared package rc4_pkg.
REQ-035 SHALL put the arm flag and watchdog in one sub-module, phase_monitor (inputs: phase-entry pulse, selected finished bit; outputs: done pulse, timeout pulse).

Verification
REQ-036 Scenario: start, key_start=0x000000, model passes each phase after 10 cycles, msg_valid=1 -> mode sequence 001,000,000,010,000,000,100; found=1; key=0x000000; busy=0.
REQ-037 Scenario: key_start=0x000005, msg_valid=0 for the first 2 keys -> found at key=0x000007 after 3 INIT passes.
REQ-038 Scenario: key_start=0x3FFFFF, msg_valid=0 -> exhausted=1; key remains 0x3FFFFF; mode=000.
REQ-039 Scenario: finished[0] held 1 at INIT entry -> no advance until it drops to 0 and rises again.
REQ-040 Scenario: finished[1] never rises -> timeout_err=1 after 4096 SHUFFLE cycles; mode=000.
REQ-041 Scenario: halt+start in the same cycle mid-DECRYPT, then reset=0 -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/rc4_pkg.sv
// ----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key-search sequencer.
//   - RAM_WIDTH_DEF / KEY_LENGTH_DEF : default key geometry (3 bytes of 8 bits)
//   - mode_t  : one-hot phase select driven to the RAM controller
//   - state_t : sequencer states
//   - mode_of / is_phase : state decode helpers shared by the top level
// ----------------------------------------------------------------------------
package rc4_pkg;

  localparam int RAM_WIDTH_DEF  = 8;
  localparam int KEY_LENGTH_DEF = 3;

  typedef enum logic [2:0] {
    MODE_IDLE    = 3'b000,
    MODE_INIT    = 3'b001,
    MODE_SHUFFLE = 3'b010,
    MODE_DECRYPT = 3'b100
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_DECRYPT,
    ST_GAP,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_ERR
  } state_t;

  // Phase select seen by the RAM controller while sitting in a given state.
  function automatic mode_t mode_of(input state_t s);
    case (s)
      ST_INIT:    return MODE_INIT;
      ST_SHUFFLE: return MODE_SHUFFLE;
      ST_DECRYPT: return MODE_DECRYPT;
      default:    return MODE_IDLE;
    endcase
  endfunction

  // True for the three states that wait on a finished flag.
  function automatic logic is_phase(input state_t s);
    return (s == ST_INIT) || (s == ST_SHUFFLE) || (s == ST_DECRYPT);
  endfunction

endpackage

// File: rtl/rc4_key_sequencer_phase_monitor.sv
// ----------------------------------------------------------------------------
// phase_monitor
// Arm flag and watchdog for whichever phase is currently running.
//   clk, reset   : clock, asynchronous active-low reset
//   i_enter      : pulse on the edge that enters a phase; clears arm + watchdog
//   i_active     : high while a phase state is current
//   i_finished   : finished bit belonging to the current phase
//   o_done       : phase completed this cycle (armed and finished seen high)
//   o_timeout    : watchdog expired this cycle without completion
// ----------------------------------------------------------------------------
module phase_monitor #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enter,
  input  logic i_active,
  input  logic i_finished,
  output logic o_done,
  output logic o_timeout
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic            r_arm;
  logic [WD_W-1:0] r_wd;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arm <= 1'b0;
      r_wd  <= '0;
    end else if (i_enter) begin
      r_arm <= 1'b0;
      r_wd  <= '0;
    end else if (i_active) begin
      // A finished bit left high by the previous pass must be seen low once
      // before a rising level is trusted as this pass's completion.
      if (!i_finished) r_arm <= 1'b1;
      if (r_wd != WD_LAST) r_wd <= r_wd + WD_W'(1);
    end
  end

  assign o_done    = i_active && r_arm && i_finished;
  // Completion takes precedence over expiry in the same cycle.
  assign o_timeout = i_active && (r_wd == WD_LAST) && !o_done;

endmodule

// File: rtl/rc4_key_sequencer.sv
// ----------------------------------------------------------------------------
// rc4_key_sequencer
// Steps an RC4 brute-force search through INIT -> SHUFFLE -> DECRYPT for each
// candidate key, with a two-cycle GAP between phases, until the decryptor
// reports a valid message, the key range is exhausted, or a phase times out.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : begin a search from key_start (only when not busy)
//   halt         : abort to IDLE (wins over start)
//   key_start    : first candidate key, byte KEY_LENGTH-1 most significant
//   finished     : done flags {decryptor, shuffler, initializer}
//   msg_valid    : decryptor verdict, meaningful while finished[2]=1
//   mode         : registered one-hot phase select (000 outside phases)
//   key          : registered current candidate key
//   busy, found, exhausted, timeout_err : registered status flags
// ----------------------------------------------------------------------------
module rc4_key_sequencer
  import rc4_pkg::*;
#(
  parameter int                                RAM_WIDTH      = RAM_WIDTH_DEF,
  parameter int                                KEY_LENGTH     = KEY_LENGTH_DEF,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0]   KEY_MAX        = 24'h3FFFFF,
  parameter int                                TIMEOUT_CYCLES = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 halt,
  input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_start,
  input  logic [2:0]                           finished,
  input  logic                                 msg_valid,
  output logic [2:0]                           mode,
  output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  output logic                                 busy,
  output logic                                 found,
  output logic                                 exhausted,
  output logic                                 timeout_err
);

  localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;

  state_t             r_state,   w_state_nx;
  mode_t              r_mode;
  logic [KEY_W-1:0]   r_key,     w_key_nx;
  logic               r_busy,    w_busy_nx;
  logic               r_found,   w_found_nx;
  logic               r_exh,     w_exh_nx;
  logic               r_terr,    w_terr_nx;
  logic               r_gap_cnt, w_gap_cnt_nx;
  state_t             r_gap_tgt, w_gap_tgt_nx;

  logic w_fin_sel;
  logic w_enter;
  logic w_done;
  logic w_timeout;

  // r_mode is one-hot in a phase, so masking picks that phase's finished bit.
  assign w_fin_sel = |(finished & r_mode);
  assign w_enter   = is_phase(w_state_nx) && (w_state_nx != r_state);

  phase_monitor #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_phase_monitor (
    .clk        (clk),
    .reset      (reset),
    .i_enter    (w_enter),
    .i_active   (is_phase(r_state)),
    .i_finished (w_fin_sel),
    .o_done     (w_done),
    .o_timeout  (w_timeout)
  );

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_key_nx     = r_key;
    w_busy_nx    = r_busy;
    w_found_nx   = r_found;
    w_exh_nx     = r_exh;
    w_terr_nx    = r_terr;
    w_gap_cnt_nx = r_gap_cnt;
    w_gap_tgt_nx = r_gap_tgt;

    if (halt) begin
      w_state_nx = ST_IDLE;
      w_busy_nx  = 1'b0;
      w_found_nx = 1'b0;
      w_exh_nx   = 1'b0;
      w_terr_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERR: begin
          if (start) begin
            w_state_nx = ST_INIT;
            w_key_nx   = key_start;
            w_busy_nx  = 1'b1;
            w_found_nx = 1'b0;
            w_exh_nx   = 1'b0;
            w_terr_nx  = 1'b0;
          end
        end

        ST_INIT, ST_SHUFFLE: begin
          if (w_done) begin
            w_state_nx   = ST_GAP;
            w_gap_cnt_nx = 1'b0;
            w_gap_tgt_nx = (r_state == ST_INIT) ? ST_SHUFFLE : ST_DECRYPT;
          end else if (w_timeout) begin
            w_state_nx = ST_ERR;
            w_busy_nx  = 1'b0;
            w_terr_nx  = 1'b1;
          end
        end

        ST_DECRYPT: begin
          if (w_done) begin
            if (msg_valid) begin
              w_state_nx = ST_FOUND;
              w_found_nx = 1'b1;
              w_busy_nx  = 1'b0;
            end else if (r_key == KEY_MAX) begin
              w_state_nx = ST_EXHAUSTED;
              w_exh_nx   = 1'b1;
              w_busy_nx  = 1'b0;
            end else begin
              // Key is one flat binary number; carries ripple across bytes.
              w_key_nx     = r_key + KEY_W'(1);
              w_state_nx   = ST_GAP;
              w_gap_cnt_nx = 1'b0;
              w_gap_tgt_nx = ST_INIT;
            end
          end else if (w_timeout) begin
            w_state_nx = ST_ERR;
            w_busy_nx  = 1'b0;
            w_terr_nx  = 1'b1;
          end
        end

        ST_GAP: begin
          // Two cycles in GAP: count 0 then count 1, leave after the second.
          if (r_gap_cnt) w_state_nx = r_gap_tgt;
          w_gap_cnt_nx = 1'b1;
        end

        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_IDLE;
      r_key     <= '0;
      r_busy    <= 1'b0;
      r_found   <= 1'b0;
      r_exh     <= 1'b0;
      r_terr    <= 1'b0;
      r_gap_cnt <= 1'b0;
      r_gap_tgt <= ST_INIT;
    end else begin
      r_state   <= w_state_nx;
      r_mode    <= mode_of(w_state_nx);
      r_key     <= w_key_nx;
      r_busy    <= w_busy_nx;
      r_found   <= w_found_nx;
      r_exh     <= w_exh_nx;
      r_terr    <= w_terr_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_gap_tgt <= w_gap_tgt_nx;
    end
  end

  assign mode        = r_mode;
  assign key         = r_key;
  assign busy        = r_busy;
  assign found       = r_found;
  assign exhausted   = r_exh;
  assign timeout_err = r_terr;

endmodule
